// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB responder state encoding and constants
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_WORD_SHIFT = 2;
  localparam int APB_MAX_WAIT   = 15;

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - single-port word memory, sync write, combinational read
module apb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are intentionally left unreset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/apb_responder_mem.sv
// rtl/apb_responder_mem.sv - APB3 completer with word memory, wait states and error response
module apb_responder_mem
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter int                    WAIT_STATES = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  Pclk,
  input  logic                  Presetn,
  input  logic                  Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH) << APB_WORD_SHIFT;
  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  apb_state_e            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] off_now;
  logic                  err_now;
  logic [IDX_W-1:0]      idx_now;
  logic [IDX_W-1:0]      idx_lat;
  logic                  err_lat;
  logic                  wr_lat;
  logic [DATA_WIDTH-1:0] data_lat;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;
  logic                  setup;
  logic                  go_access;
  logic                  entry_err;
  logic                  entry_wr;

  assign setup   = Psel && !Penable;
  assign off_now = Paddr - BASE_ADDR;
  assign err_now = (Paddr < BASE_ADDR) || ({1'b0, off_now} >= LIMIT) || (Paddr[1:0] != 2'b00);
  assign idx_now = off_now[APB_WORD_SHIFT +: IDX_W];

  // With zero wait states ACCESS is entered from the setup edge, before anything is latched.
  assign go_access = (state == IDLE && setup && NO_WAIT) ||
                     (state == WAIT && Psel && cnt <= 4'd1);
  assign entry_err = (state == IDLE) ? err_now : err_lat;
  assign entry_wr  = (state == IDLE) ? Pwrite  : wr_lat;

  assign mem_idx = (state == IDLE) ? idx_now : idx_lat;
  assign mem_we  = (state == ACCESS) && Psel && Penable && wr_lat && !err_lat;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (Pclk),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (data_lat),
    .rdata (mem_rdata)
  );

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state    <= IDLE;
      cnt      <= '0;
      Pready   <= 1'b0;
      Pslverr  <= 1'b0;
      Prdata   <= '0;
      idx_lat  <= '0;
      err_lat  <= 1'b0;
      wr_lat   <= 1'b0;
      data_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            idx_lat  <= idx_now;
            err_lat  <= err_now;
            wr_lat   <= Pwrite;
            data_lat <= Pdata;
            if (NO_WAIT) begin
              state <= ACCESS;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!Psel) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt <= 4'd1) begin
            state <= ACCESS;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS: begin
          // Closing edge or abort; a stray setup here is ignored.
          if (!Psel || Penable) begin
            state   <= IDLE;
            Pready  <= 1'b0;
            Pslverr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (go_access) begin
        Pready  <= 1'b1;
        Pslverr <= entry_err;
        if (!entry_wr) Prdata <= entry_err ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_responder_mem.sv
// tb/tb_apb_responder_mem.sv - table and scoreboard bench for apb_responder_mem
module tb_apb_responder_mem;

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          waits;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          waits;
  } exp_t;

  logic        pclk;
  logic        presetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  apb_responder_mem #(.WAIT_STATES(0)) u_ws0 (
    .Pclk(pclk), .Presetn(presetn), .Psel(psel[0]), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pdata(pdata), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0])
  );
  apb_responder_mem #(.WAIT_STATES(2)) u_ws2 (
    .Pclk(pclk), .Presetn(presetn), .Psel(psel[1]), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pdata(pdata), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1])
  );
  apb_responder_mem #(.WAIT_STATES(3)) u_ws3 (
    .Pclk(pclk), .Presetn(presetn), .Psel(psel[2]), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pdata(pdata), .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2])
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] rd, input bit err, input int waits);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    e.waits = waits;
    sb.push_back(e);
  endtask

  // Starts at posedge+1, ends at posedge+1 after the closing edge with the bus idle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int   n;
    exp_t e;
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pdata   = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready[d] && n < 40) begin
      @(posedge pclk); #1;
      n++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("pready_seen", 32'(pready[d]), 32'd1);
      chk("wait_cycles", 32'(n), 32'(e.waits));
      chk("prdata", prdata[d], e.rdata);
      chk("pslverr", 32'(pslverr[d]), 32'(e.err));
    end
    @(posedge pclk); #1;
    psel    = '0;
    penable = 1'b0;
    chk("pready_after_close", 32'(pready[d]), 32'd0);
    chk("pslverr_after_close", 32'(pslverr[d]), 32'd0);
  endtask

  initial begin
    vec_t tbl[14];
    int   c0;

    presetn = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pdata   = '0;

    tbl[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 0};
    tbl[1]  = '{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0};
    tbl[2]  = '{0, 1'b1, 32'h0,   32'h11111111, 32'hDEADBEEF, 1'b0, 0};
    tbl[3]  = '{0, 1'b1, 32'h400, 32'hBAD0BAD0, 32'hDEADBEEF, 1'b1, 0};
    tbl[4]  = '{0, 1'b1, 32'h13,  32'hBAD1BAD1, 32'hDEADBEEF, 1'b1, 0};
    tbl[5]  = '{0, 1'b0, 32'h0,   32'h0,        32'h11111111, 1'b0, 0};
    tbl[6]  = '{0, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 0};
    tbl[7]  = '{0, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0, 0};
    tbl[8]  = '{0, 1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, 0};
    tbl[9]  = '{0, 1'b0, 32'h2,   32'h0,        32'h0,        1'b1, 0};
    tbl[10] = '{2, 1'b1, 32'h20,  32'h12345678, 32'h0,        1'b0, 3};
    tbl[11] = '{2, 1'b0, 32'h20,  32'h0,        32'h12345678, 1'b0, 3};
    tbl[12] = '{1, 1'b1, 32'h40,  32'hA5A5A5A5, 32'h0,        1'b0, 2};
    tbl[13] = '{1, 1'b0, 32'h40,  32'h0,        32'hA5A5A5A5, 1'b0, 2};

    #3;
    for (int i = 0; i < 3; i++) begin
      chk("reset_prdata", prdata[i], 32'h0);
      chk("reset_pready", 32'(pready[i]), 32'd0);
      chk("reset_pslverr", 32'(pslverr[i]), 32'd0);
    end
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;

    for (int i = 0; i < 14; i++) begin
      push(tbl[i].rdata, tbl[i].err, tbl[i].waits);
      xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      @(posedge pclk); #1;
    end

    // Back-to-back, zero wait states: 6 transfers in 12 cycles.
    c0 = cyc;
    push(32'h0, 1'b0, 0);        xfer(0, 1'b1, 32'h0, 32'hA0A0A0A0);
    push(32'h0, 1'b0, 0);        xfer(0, 1'b1, 32'h4, 32'hB1B1B1B1);
    push(32'h0, 1'b0, 0);        xfer(0, 1'b1, 32'h8, 32'hC2C2C2C2);
    push(32'hA0A0A0A0, 1'b0, 0); xfer(0, 1'b0, 32'h0, 32'h0);
    push(32'hB1B1B1B1, 1'b0, 0); xfer(0, 1'b0, 32'h4, 32'h0);
    push(32'hC2C2C2C2, 1'b0, 0); xfer(0, 1'b0, 32'h8, 32'h0);
    chk("b2b_ws0_cycles", 32'(cyc - c0), 32'd12);

    // Back-to-back, three wait states: 3 transfers in 15 cycles.
    c0 = cyc;
    push(32'h12345678, 1'b0, 3); xfer(2, 1'b1, 32'h24, 32'h0F0F0F0F);
    push(32'h0F0F0F0F, 1'b0, 3); xfer(2, 1'b0, 32'h24, 32'h0);
    push(32'h12345678, 1'b0, 3); xfer(2, 1'b0, 32'h20, 32'h0);
    chk("b2b_ws3_cycles", 32'(cyc - c0), 32'd15);
    @(posedge pclk); #1;

    // Psel dropped during WAIT aborts the write.
    push(32'hA5A5A5A5, 1'b0, 2); xfer(1, 1'b1, 32'h80, 32'h77777777);
    psel    = 3'b010;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h80;
    pdata   = 32'hBADBAD00;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("abort_wait_pready", 32'(pready[1]), 32'd0);
    psel    = '0;
    penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk("abort_idle_pready", 32'(pready[1]), 32'd0);
    end
    push(32'h77777777, 1'b0, 2); xfer(1, 1'b0, 32'h80, 32'h0);
    @(posedge pclk); #1;

    // Reset in the middle of a WAIT on a write.
    push(32'h12345678, 1'b0, 3); xfer(2, 1'b1, 32'h40, 32'h13579BDF);
    push(32'h13579BDF, 1'b0, 3); xfer(2, 1'b0, 32'h40, 32'h0);
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h40;
    pdata   = 32'hFFFFFFFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #3;
    presetn = 1'b0;
    #1;
    chk("async_rst_prdata_ws3", prdata[2], 32'h0);
    chk("async_rst_pready_ws3", 32'(pready[2]), 32'd0);
    chk("async_rst_pslverr_ws3", 32'(pslverr[2]), 32'd0);
    chk("async_rst_prdata_ws2", prdata[1], 32'h0);
    psel    = '0;
    penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    push(32'h13579BDF, 1'b0, 3); xfer(2, 1'b0, 32'h40, 32'h0);
    push(32'h77777777, 1'b0, 2); xfer(1, 1'b0, 32'h80, 32'h0);
    push(32'hCAFEF00D, 1'b0, 0); xfer(0, 1'b0, 32'h3FC, 32'h0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
